rv32i_fetch_stage: RTL

- Instruction fetch stage for the single-issue RV32I core. Sits between the synchronous instruction ROM (`I_mem`) and the decode stage.
- Owns the fetch PC and issues word reads to `I_mem`.
- Buffers returned instructions in a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- Accepts PC redirects from execute (branches, jumps) and flushes stale instructions.

---
 rtl/rv32i_fetch_stage.sv | 111 +++++++++++
 1 files changed

// File: rtl/rv32i_fetch_stage.sv
// RV32I instruction fetch: owns the fetch PC, issues word reads to I_mem and
// buffers responses in a small prefetch FIFO that feeds decode over valid/ready.
module rv32i_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_ADDR_W = 10,
    parameter int          DEPTH       = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_en,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [31:0]            imem_rdata,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   if_valid,
    input  logic                   if_ready,
    output logic [31:0]            if_instr,
    output logic [31:0]            if_pc,
    output logic                   redirect_misalign
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1) + 1;

    logic              rst_n_q;
    logic [31:0]       fetch_pc;
    logic [31:0]       pend_pc;
    logic              pending;
    logic              kill;
    logic [OCC_W-1:0]  occ;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [31:0]       mem_pc    [DEPTH];
    logic [31:0]       mem_instr [DEPTH];
    logic              misalign_q;

    logic              pop;
    logic              push;
    logic              issue;
    logic [OCC_W:0]    level;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    // Slots committed after this cycle: buffered + in flight - leaving now.
    always_comb begin
        pop   = if_valid & if_ready;
        level = (OCC_W + 1)'(occ) + (OCC_W + 1)'(pending) - (OCC_W + 1)'(pop);
        issue = rst_n & rst_n_q & ~redirect_valid & (level < (OCC_W + 1)'(DEPTH));
        push  = pending & ~kill & ~redirect_valid;
    end

    assign imem_en           = issue;
    assign imem_addr         = fetch_pc[IMEM_ADDR_W+1:2];
    assign if_valid          = (occ != '0);
    assign if_instr          = mem_instr[rd_ptr];
    assign if_pc             = mem_pc[rd_ptr];
    assign redirect_misalign = misalign_q;

    always_ff @(posedge clk) begin
        rst_n_q <= rst_n;
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            pend_pc    <= '0;
            pending    <= 1'b0;
            kill       <= 1'b0;
            occ        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            misalign_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]    <= '0;
                mem_instr[i] <= '0;
            end
        end else begin
            misalign_q <= redirect_valid & (|redirect_pc[1:0]);
            if (redirect_valid) begin
                // Any response still in flight belongs to the old path.
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                pending  <= 1'b0;
                kill     <= pending;
                occ      <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                kill <= 1'b0;
                if (issue) begin
                    pending  <= 1'b1;
                    pend_pc  <= fetch_pc;
                    fetch_pc <= fetch_pc + 32'd4;
                end else begin
                    pending <= 1'b0;
                end
                if (push) begin
                    mem_pc[wr_ptr]    <= pend_pc;
                    mem_instr[wr_ptr] <= imem_rdata;
                    wr_ptr            <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                case ({push, pop})
                    2'b10:   occ <= occ + OCC_W'(1);
                    2'b01:   occ <= occ - OCC_W'(1);
                    default: occ <= occ;
                endcase
            end
        end
    end
endmodule
